// File: rtl/aes_round_sequencer.sv
// AES round sequencer: steps the add-key, key-expansion, sub-bytes, shift-rows and
// mix-columns units through NR rounds, with a per-step acknowledge watchdog.
module aes_round_sequencer #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       i_key_addition,
    input  logic       i_round_key_get_ready,
    input  logic       i_byte_subs,
    input  logic       i_shift_rows,
    input  logic       i_mix_columns,
    output logic       o_add,
    output logic       o_calc_round_key,
    output logic       o_substitute,
    output logic       o_shift_rows,
    output logic       o_mix_columns,
    output logic [3:0] round_cnt,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_ADD,
        S_KEY,
        S_SUB,
        S_SHIFT,
        S_MIX,
        S_ADD,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [5:0] WD_LIMIT   = 6'(TIMEOUT - 1);

    state_t     state, state_nx;
    logic       cmd_cycle;
    logic [5:0] wd;
    logic       in_wait, ack, accept, timeout, entering;
    logic       add_nx, key_nx, sub_nx, shift_nx, mix_nx;
    logic       busy_nx, done_nx, err_nx;

    // Ack routing; the command cycle itself never counts as an acknowledge.
    always_comb begin
        in_wait = 1'b0;
        ack     = 1'b0;
        case (state)
            S_INIT_ADD, S_ADD: begin in_wait = 1'b1; ack = i_key_addition;        end
            S_KEY:             begin in_wait = 1'b1; ack = i_round_key_get_ready; end
            S_SUB:             begin in_wait = 1'b1; ack = i_byte_subs;           end
            S_SHIFT:           begin in_wait = 1'b1; ack = i_shift_rows;          end
            S_MIX:             begin in_wait = 1'b1; ack = i_mix_columns;         end
            default:           ;
        endcase
        accept  = in_wait && !cmd_cycle && ack;
        timeout = in_wait && !accept && (wd == WD_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (start)  state_nx = S_INIT_ADD;
            S_INIT_ADD: if (accept) state_nx = S_KEY;
            S_KEY:      if (accept) state_nx = S_SUB;
            S_SUB:      if (accept) state_nx = S_SHIFT;
            S_SHIFT:    if (accept) state_nx = (round_cnt < LAST_ROUND) ? S_MIX : S_ADD;
            S_MIX:      if (accept) state_nx = S_ADD;
            S_ADD:      if (accept) state_nx = (round_cnt < LAST_ROUND) ? S_KEY : S_DONE;
            S_DONE:     state_nx = S_IDLE;
            S_ERR:      if (start)  state_nx = S_INIT_ADD;
            default:    state_nx = S_IDLE;
        endcase
        if (timeout) state_nx = S_ERR;
    end

    // Every transition changes state, so a command fires exactly on wait-state entry.
    always_comb begin
        entering = (state_nx != state);
        add_nx   = entering && (state_nx == S_INIT_ADD || state_nx == S_ADD);
        key_nx   = entering && (state_nx == S_KEY);
        sub_nx   = entering && (state_nx == S_SUB);
        shift_nx = entering && (state_nx == S_SHIFT);
        mix_nx   = entering && (state_nx == S_MIX);
        busy_nx  = !(state_nx == S_IDLE || state_nx == S_ERR);
        done_nx  = (state_nx == S_DONE);
        err_nx   = (state_nx == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            o_add            <= 1'b0;
            o_calc_round_key <= 1'b0;
            o_substitute     <= 1'b0;
            o_shift_rows     <= 1'b0;
            o_mix_columns    <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_error          <= 1'b0;
            cmd_cycle        <= 1'b0;
            wd               <= '0;
            round_cnt        <= '0;
        end else begin
            o_add            <= add_nx;
            o_calc_round_key <= key_nx;
            o_substitute     <= sub_nx;
            o_shift_rows     <= shift_nx;
            o_mix_columns    <= mix_nx;
            o_busy           <= busy_nx;
            o_done           <= done_nx;
            o_error          <= err_nx;
            cmd_cycle        <= add_nx | key_nx | sub_nx | shift_nx | mix_nx;
            if (entering)     wd <= '0;
            else if (in_wait) wd <= wd + 6'd1;
            if (state == S_KEY && accept)
                round_cnt <= round_cnt + 4'd1;
            else if (state_nx == S_IDLE || state_nx == S_INIT_ADD)
                round_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized bench for aes_round_sequencer: a step-list model of the AES command
// sequence plays the ack responder and predicts every output cycle by cycle.
module tb_aes_round_sequencer;
    localparam int NR      = 10;
    localparam int TIMEOUT = 32;
    localparam int C_ADD = 0, C_KEY = 1, C_SUB = 2, C_SHIFT = 3, C_MIX = 4;

    logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic       i_key_addition = 1'b0, i_round_key_get_ready = 1'b0, i_byte_subs = 1'b0;
    logic       i_shift_rows = 1'b0, i_mix_columns = 1'b0;
    logic       o_add, o_calc_round_key, o_substitute, o_shift_rows, o_mix_columns;
    logic [3:0] round_cnt;
    logic       o_busy, o_done, o_error;

    int checks = 0, errors = 0;
    int pulse_cnt[5];
    int done_at;
    int q[$];

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(NR), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .i_key_addition(i_key_addition), .i_round_key_get_ready(i_round_key_get_ready),
        .i_byte_subs(i_byte_subs), .i_shift_rows(i_shift_rows), .i_mix_columns(i_mix_columns),
        .o_add(o_add), .o_calc_round_key(o_calc_round_key), .o_substitute(o_substitute),
        .o_shift_rows(o_shift_rows), .o_mix_columns(o_mix_columns),
        .round_cnt(round_cnt), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    task automatic drive_acks(input logic [4:0] a);
        i_key_addition        = a[C_ADD];
        i_round_key_get_ready = a[C_KEY];
        i_byte_subs           = a[C_SUB];
        i_shift_rows          = a[C_SHIFT];
        i_mix_columns         = a[C_MIX];
    endtask

    function automatic logic [4:0] cmds();
        return {o_mix_columns, o_shift_rows, o_substitute, o_calc_round_key, o_add};
    endfunction

    function automatic int pick(input int code, input bit noisy, input int dmin, input int dmax);
        if (noisy && code == C_MIX) return 1;  // mix ack line is held high in noisy runs
        return int'($urandom_range(dmax, dmin));
    endfunction

    // One encryption from start. Each step's ack arrives d cycles after its command.
    task automatic run_job(input int dmin, input int dmax, input bit noisy,
                           input int tmo_round, input int rst_round, input int bstart_round);
        int idx, e, d, keys, n, err_at, code, exp_rc;
        logic [4:0] obs, exp_cmd, acks;
        logic exp_busy, exp_done, exp_err;
        bit chk_rc, fin;
        q.delete();
        q.push_back(C_ADD);
        for (int r = 1; r <= NR; r++) begin
            q.push_back(C_KEY); q.push_back(C_SUB); q.push_back(C_SHIFT);
            if (r < NR) q.push_back(C_MIX);
            q.push_back(C_ADD);
        end
        for (int c = 0; c < 5; c++) pulse_cnt[c] = 0;
        idx = 0; e = 0; keys = 0; n = 0; err_at = -1; done_at = -1; fin = 0;
        d = pick(q[0], noisy, dmin, dmax);
        drive_acks(5'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin) begin
            obs = cmds();
            for (int c = 0; c < 5; c++) if (obs[c]) pulse_cnt[c]++;
            chk_rc = 1; exp_err = 1'b0; exp_rc = 0;
            if (err_at >= 0 && n >= err_at) begin
                exp_cmd = '0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b1; chk_rc = 0;
            end else if (done_at >= 0 && n == done_at) begin
                exp_cmd = '0; exp_busy = 1'b1; exp_done = 1'b1; exp_rc = NR;
            end else if (done_at >= 0) begin
                exp_cmd = '0; exp_busy = 1'b0; exp_done = 1'b0; exp_rc = 0;
            end else begin
                exp_cmd = (n == e) ? 5'(1 << q[idx]) : 5'b0;
                exp_busy = 1'b1; exp_done = 1'b0; exp_rc = keys;
            end
            checks++;
            if (obs !== exp_cmd) begin
                errors++; $display("FAIL cmd n=%0d got %b want %b", n, obs, exp_cmd);
            end
            checks++;
            if (o_busy !== exp_busy) begin
                errors++; $display("FAIL busy n=%0d got %b want %b", n, o_busy, exp_busy);
            end
            checks++;
            if (o_done !== exp_done) begin
                errors++; $display("FAIL done n=%0d got %b want %b", n, o_done, exp_done);
            end
            checks++;
            if (o_error !== exp_err) begin
                errors++; $display("FAIL error n=%0d got %b want %b", n, o_error, exp_err);
            end
            if (chk_rc) begin
                checks++;
                if (round_cnt !== 4'(exp_rc)) begin
                    errors++; $display("FAIL round_cnt n=%0d got %0d want %0d", n, round_cnt, exp_rc);
                end
            end
            if (done_at >= 0 && n >= done_at + 2) fin = 1;
            else if (err_at >= 0 && n >= err_at + 4) fin = 1;
            else if (n >= 4000) begin
                checks++; errors++;
                $display("FAIL job_budget n=%0d got no completion want completion", n);
                fin = 1;
            end
            if (!fin) begin
                acks = '0;
                start = 1'b0;
                if (done_at < 0 && err_at < 0) begin
                    code = q[idx];
                    if (rst_round > 0 && code == C_SHIFT && keys == rst_round && n == e + 1) begin
                        reset = 1'b0; start = 1'b1; drive_acks(5'h1f);
                        @(posedge clk); #1;
                        checks++;
                        if ({cmds(), o_busy, o_done, o_error} !== 8'b0 || round_cnt !== 4'd0) begin
                            errors++;
                            $display("FAIL mid_reset got cmd=%b busy=%b done=%b err=%b rc=%0d want all 0",
                                     cmds(), o_busy, o_done, o_error, round_cnt);
                        end
                        reset = 1'b1; start = 1'b0; drive_acks(5'b0);
                        for (int k = 0; k < 4; k++) begin
                            @(posedge clk); #1;
                            checks++;
                            if (cmds() !== 5'b0 || o_busy !== 1'b0) begin
                                errors++;
                                $display("FAIL post_reset_idle got cmd=%b busy=%b want 0", cmds(), o_busy);
                            end
                        end
                        return;
                    end
                    if (noisy) begin
                        acks = 5'($urandom);
                        acks[C_MIX] = 1'b1;
                        if (code == C_KEY) acks[C_SUB] = 1'b1;
                        if (code != C_MIX) acks[code] = (n == e) ? 1'($urandom) : 1'b0;
                    end
                    if (tmo_round > 0 && code == C_SUB && keys == tmo_round) begin
                        err_at = e + TIMEOUT;
                    end else if (n == e + d) begin
                        acks[code] = 1'b1;
                        idx++;
                        if (code == C_KEY) keys++;
                        if (idx == q.size()) done_at = n + 1;
                        else begin
                            e = n + 1;
                            d = pick(q[idx], noisy, dmin, dmax);
                        end
                    end
                    if (bstart_round > 0 && code == C_SUB && keys == bstart_round && n == e) start = 1'b1;
                end
                drive_acks(acks);
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        drive_acks(5'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; drive_acks(5'h1f);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({cmds(), o_busy, o_done, o_error} !== 8'b0 || round_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_state got cmd=%b busy=%b done=%b err=%b rc=%0d want all 0",
                         cmds(), o_busy, o_done, o_error, round_cnt);
            end
        end
        reset = 1'b1; start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_acks(5'($urandom));
            @(posedge clk); #1;
            checks++;
            if (cmds() !== 5'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_cmd got cmd=%b busy=%b want 0", cmds(), o_busy);
            end
        end
        drive_acks(5'b0);
    endtask

    task automatic test_nominal();
        int want[5];
        run_job(1, 1, 0, 0, 0, 0);
        checks++;
        if (done_at !== 100) begin
            errors++; $display("FAIL nominal_done_cycle got %0d want 100", done_at);
        end
        want[C_ADD] = NR + 1; want[C_KEY] = NR; want[C_SUB] = NR; want[C_SHIFT] = NR; want[C_MIX] = NR - 1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (pulse_cnt[c] !== want[c]) begin
                errors++; $display("FAIL nominal_pulses cmd%0d got %0d want %0d", c, pulse_cnt[c], want[c]);
            end
        end
    endtask

    task automatic test_slow_acks();
        run_job(5, 5, 0, 0, 0, 0);
        checks++;
        if (done_at !== 300) begin
            errors++; $display("FAIL slow_done_cycle got %0d want 300", done_at);
        end
        checks++;
        if (pulse_cnt[C_MIX] !== NR - 1 || pulse_cnt[C_ADD] !== NR + 1) begin
            errors++;
            $display("FAIL slow_pulses got mix=%0d add=%0d want %0d %0d",
                     pulse_cnt[C_MIX], pulse_cnt[C_ADD], NR - 1, NR + 1);
        end
    endtask

    task automatic test_watchdog_edge();
        run_job(TIMEOUT - 1, TIMEOUT - 1, 0, 0, 0, 0);
        checks++;
        if (done_at !== 50 * TIMEOUT) begin
            errors++; $display("FAIL wd_edge_done got %0d want %0d", done_at, 50 * TIMEOUT);
        end
    endtask

    task automatic test_ack_hygiene();
        for (int k = 0; k < 3; k++) begin
            run_job(1, 8, 1, 0, 0, 0);
            checks++;
            if (done_at < 0 || pulse_cnt[C_MIX] !== NR - 1) begin
                errors++;
                $display("FAIL hygiene_run got done_at=%0d mix=%0d want >=0 and %0d", done_at, pulse_cnt[C_MIX], NR - 1);
            end
        end
    endtask

    task automatic test_timeout();
        run_job(1, 3, 0, 3, 0, 0);
        run_job(1, 1, 0, 0, 0, 0);
        checks++;
        if (done_at !== 100) begin
            errors++; $display("FAIL restart_after_err got %0d want 100", done_at);
        end
    endtask

    task automatic test_reset_midrun();
        run_job(1, 4, 0, 0, 5, 0);
        run_job(1, 1, 0, 0, 0, 0);
        checks++;
        if (done_at !== 100) begin
            errors++; $display("FAIL run_after_reset got %0d want 100", done_at);
        end
    endtask

    task automatic test_start_while_busy();
        run_job(1, 1, 0, 0, 0, 2);
        checks++;
        if (done_at !== 100) begin
            errors++; $display("FAIL start_busy_done got %0d want 100", done_at);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_slow_acks();
        test_watchdog_edge();
        test_ack_hygiene();
        test_timeout();
        test_reset_midrun();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning the number of AES rounds (AES-128).
REQ-002 The block SHALL have parameter TIMEOUT, default 32, meaning the maximum wait cycles for an acknowledge before error (range 2..63).
REQ-003 clk  input  1  meaning: single clock; all state changes on the rising edge.
REQ-004 reset  input  1  meaning: synchronous, active-low reset.
REQ-005 start  input  1  meaning: begin one encryption; sampled only in IDLE or ERR.
REQ-006 i_key_addition, i_round_key_get_ready, i_byte_subs, i_shift_rows, i_mix_columns  input  1 each  meaning: completion acks from the add-key, key-expansion, sub-bytes, shift-rows and mix-columns units.
REQ-007 o_add, o_calc_round_key, o_substitute, o_shift_rows, o_mix_columns  output  1 each  meaning: one-cycle registered command pulses to the matching unit.
REQ-008 round_cnt  output  4  meaning: current round, 0..NR.
REQ-009 o_busy  output  1  meaning: an encryption is in progress.
REQ-010 o_done  output  1  meaning: one-cycle pulse when the final AddRoundKey is acknowledged.
REQ-011 o_error  output  1  meaning: a watchdog timeout occurred; held high until cleared.

Function
REQ-012 States SHALL be IDLE, INIT_ADD, KEY, SUB, SHIFT, MIX, ADD, DONE, ERR.
REQ-013 IDLE with start=1 SHALL go to INIT_ADD; start in any other state except ERR SHALL be ignored.
REQ-014 On entry to each wait state, the matching command SHALL pulse high for exactly the first cycle: INIT_ADD/ADD→o_add, KEY→o_calc_round_key, SUB→o_substitute, SHIFT→o_shift_rows, MIX→o_mix_columns.
REQ-015 An ack SHALL be accepted only in its own wait state and only in cycles after the command pulse; an ack in the command cycle, or a non-matching ack, SHALL be ignored.
REQ-016 Transitions on accepted ack SHALL be: INIT_ADD→KEY; KEY→SUB; SUB→SHIFT; SHIFT→MIX if round_cnt<NR, else ADD; MIX→ADD; ADD→KEY if round_cnt<NR, else DONE.
REQ-017 round_cnt SHALL be 0 in IDLE and INIT_ADD, SHALL increment by 1 when the KEY ack is accepted, and SHALL never exceed NR.
REQ-018 DONE SHALL last one cycle with o_done=1, then go to IDLE with round_cnt cleared to 0.
REQ-019 o_busy SHALL be 1 in every state except IDLE and ERR.
REQ-020 A watchdog counter SHALL clear on each command pulse and increment each wait-state cycle without an accepted ack.
REQ-021 When the watchdog reaches TIMEOUT, the block SHALL enter ERR with o_error=1; all commands and o_busy SHALL be 0 in ERR.
REQ-022 ERR with start=1 SHALL clear o_error and go to INIT_ADD with round_cnt=0.
REQ-023 With every ack returned in the cycle after its command, o_done SHALL be high exactly in cycle 101 after the edge that samples start. This is 50 steps of 2 cycles each: 1 initial add, 9×5 full rounds, and a 4-step final round without MIX.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 reset=0 at any rising edge, including mid-encryption, SHALL force IDLE, round_cnt=0, watchdog=0, and all command outputs, o_busy, o_done and o_error to 0 from the next cycle.
REQ-026 reset SHALL take priority over start and all acks sampled at the same edge.
REQ-027 After reset is released, no command SHALL issue until start=1 is sampled.

Verification
REQ-028 Nominal run: reset low for 5 cycles, start for 1 cycle, each ack returned 1 cycle after its command → 10 o_substitute, 10 o_shift_rows, 9 o_mix_columns, 11 o_add and 10 o_calc_round_key pulses; o_done in cycle 101; round_cnt reaches 10, then returns to 0.
REQ-029 Slow acks: each ack delayed 5 cycles → same pulse counts, no o_error, each step lasting 6 cycles.
REQ-030 Timeout: i_byte_subs withheld in round 3 → o_error=1 and o_busy=0 after 32 wait cycles, no further commands; start then restarts with o_add and round_cnt=0.
REQ-031 Ack hygiene: i_mix_columns held high throughout, and a stray i_byte_subs asserted during KEY → neither changes state; the final round issues no o_mix_columns.
REQ-032 Reset mid-run: reset low during round 5 SHIFT → all outputs 0 the next cycle; a second start completes normally.
REQ-033 Start while busy: start pulsed in round 2 → ignored, single o_done at cycle 101.
